// File: rtl/chunk_row_sched.sv
// chunk_row_sched: emits one row descriptor per handshake over a vertical tile window.
// Optional vertical wrap enabled by defining CHUNK_ROW_SCHED_WRAP_EN.
package TauCfg;
   localparam int GLOBAL_ADDR_BW = 32;
   localparam int VSIZE = 16;
endpackage

module chunk_row_sched #(
   parameter int GBW = TauCfg::GLOBAL_ADDR_BW,
   parameter int VSIZE = TauCfg::VSIZE,
   parameter int CNT_BW = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     cfg_rdy,
   output logic                     cfg_ack,
   input  logic [GBW-1:0]           i_base,
   input  logic [GBW-1:0]           i_stride,
   input  logic [CNT_BW-1:0]        i_ystart,
   input  logic [CNT_BW-1:0]        i_nrow,
   input  logic [CNT_BW-1:0]        i_ybound,
   input  logic [$clog2(VSIZE)-1:0] i_pad,
`ifdef CHUNK_ROW_SCHED_WRAP_EN
   input  logic                     i_wrap,
   input  logic [GBW-1:0]           i_span,
`endif
   output logic                     row_rdy,
   input  logic                     row_ack,
   output logic [GBW-1:0]           o_row_linear,
   output logic                     o_row_islast,
   output logic [$clog2(VSIZE)-1:0] o_row_pad,
   output logic                     o_row_valid,
   output logic                     o_busy
);
   localparam int V_BW = $clog2(VSIZE);
   typedef enum logic {IDLE, EMIT} state_t;
   state_t state, state_nx;
   logic [CNT_BW-1:0] y, y_inc, remain, ybound;
   logic [GBW-1:0] lin, lin_nx, stride;
   logic [V_BW-1:0] pad;
   logic accept, step, wrap_hit, emit;
`ifdef CHUNK_ROW_SCHED_WRAP_EN
   logic wrap;
   logic [GBW-1:0] span;
   assign wrap_hit = wrap && y_inc == ybound;
   assign lin_nx = wrap_hit ? lin + stride - span : lin + stride;
`else
   assign wrap_hit = 1'b0;
   assign lin_nx = lin + stride;
`endif
   assign y_inc = y + CNT_BW'(1);
   always_comb begin
      emit = state == EMIT;
      accept = !emit && cfg_rdy;
      step = emit && row_ack;
      state_nx = accept && i_nrow != '0 ? EMIT : step && remain == CNT_BW'(1) ? IDLE : state;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         y <= '0;
         lin <= '0;
         remain <= '0;
         stride <= '0;
         ybound <= '0;
         pad <= '0;
`ifdef CHUNK_ROW_SCHED_WRAP_EN
         wrap <= 1'b0;
         span <= '0;
`endif
      end else begin
         state <= state_nx;
         if (accept) begin
            y <= i_ystart;
            lin <= i_base;
            remain <= i_nrow;
            stride <= i_stride;
            ybound <= i_ybound;
            pad <= i_pad;
`ifdef CHUNK_ROW_SCHED_WRAP_EN
            wrap <= i_wrap;
            span <= i_span;
`endif
         end else if (step) begin
            y <= wrap_hit ? '0 : y_inc;
            lin <= lin_nx;
            remain <= remain - CNT_BW'(1);
         end
      end
   end
   // descriptor fields read as zero outside EMIT so IDLE never shows a stale row
   assign cfg_ack = accept;
   assign row_rdy = emit;
   assign o_busy = emit;
   assign o_row_linear = emit ? lin : '0;
   assign o_row_pad = emit ? pad : '0;
   assign o_row_islast = emit && remain == CNT_BW'(1);
   assign o_row_valid = emit && !y[CNT_BW-1] && y < ybound;
endmodule

// File: tb/tb_chunk_row_sched.sv
// tb_chunk_row_sched: table-driven cycle vectors plus reset sequences for chunk_row_sched.
module tb_chunk_row_sched;
   logic i_clk = 1'b0, i_rst = 1'b1;
   logic cfg_rdy = 1'b0, row_ack = 1'b0, i_wrap = 1'b0;
   logic [31:0] i_base = '0, i_stride = '0, i_span = '0;
   logic [15:0] i_ystart = '0, i_nrow = '0, i_ybound = '0;
   logic [3:0] i_pad = '0;
   logic cfg_ack, row_rdy, o_row_islast, o_row_valid, o_busy;
   logic [31:0] o_row_linear;
   logic [3:0] o_row_pad;
   int checks = 0, errors = 0;

   chunk_row_sched dut (
      .i_clk(i_clk), .i_rst(i_rst), .cfg_rdy(cfg_rdy), .cfg_ack(cfg_ack),
      .i_base(i_base), .i_stride(i_stride), .i_ystart(i_ystart), .i_nrow(i_nrow),
      .i_ybound(i_ybound), .i_pad(i_pad),
`ifdef CHUNK_ROW_SCHED_WRAP_EN
      .i_wrap(i_wrap), .i_span(i_span),
`endif
      .row_rdy(row_rdy), .row_ack(row_ack), .o_row_linear(o_row_linear),
      .o_row_islast(o_row_islast), .o_row_pad(o_row_pad), .o_row_valid(o_row_valid),
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] base, stride, span;
      logic [15:0] ys, nr, yb;
      logic [3:0] pad;
      logic wrap;
   } cfg_t;
   typedef struct {
      string n;
      logic cr;
      int ci;
      logic ack, cack, rdy;
      logic [31:0] lin;
      logic val, last;
      logic [3:0] pad;
   } vec_t;
   cfg_t cfgs[8];
   vec_t vq[$];

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_cfg(input logic cr, input cfg_t c, input logic ack);
      cfg_rdy = cr;
      row_ack = ack;
      i_base = c.base;
      i_stride = c.stride;
      i_ystart = c.ys;
      i_nrow = c.nr;
      i_ybound = c.yb;
      i_pad = c.pad;
      i_wrap = c.wrap;
      i_span = c.span;
   endtask

   task automatic chk(input string n, input logic cack, input logic rdy, input logic [31:0] lin,
                      input logic val, input logic last, input logic [3:0] pad);
      @(negedge i_clk);
      checks++;
      if ({cfg_ack, row_rdy, o_row_linear, o_row_valid, o_row_islast, o_row_pad, o_busy} !==
          {cack, rdy, lin, val, last, pad, rdy}) begin
         errors++;
         $display("FAIL %s: got cack=%0b rdy=%0b lin=%h val=%0b last=%0b pad=%h busy=%0b, expected cack=%0b rdy=%0b lin=%h val=%0b last=%0b pad=%h busy=%0b",
                  n, cfg_ack, row_rdy, o_row_linear, o_row_valid, o_row_islast, o_row_pad, o_busy,
                  cack, rdy, lin, val, last, pad, rdy);
      end
   endtask

   initial begin
      cfgs[0] = '{32'h1000, 32'h40, 32'h0, 16'h0, 16'd3, 16'd8, 4'h0, 1'b0};
      cfgs[1] = '{32'h2000, 32'h100, 32'h0, 16'hFFFE, 16'd4, 16'd8, 4'h3, 1'b0};
      cfgs[2] = '{32'hDEAD0000, 32'h1, 32'h0, 16'h0, 16'd1, 16'd8, 4'hF, 1'b0};
      cfgs[3] = '{32'h3000, 32'hFFFFFFE0, 32'h0, 16'd6, 16'd4, 16'd8, 4'h1, 1'b0};
      cfgs[4] = '{32'h7000, 32'h4, 32'h0, 16'h0, 16'd0, 16'd8, 4'h0, 1'b0};
      cfgs[5] = '{32'h4000, 32'h4, 32'h0, 16'd7, 16'd1, 16'd8, 4'h2, 1'b0};
      cfgs[6] = '{32'h8000, 32'h4, 32'h0, 16'h8000, 16'd1, 16'hFFFF, 4'h0, 1'b0};
      cfgs[7] = '{32'h120, 32'h10, 32'h40, 16'd2, 16'd4, 16'd4, 4'h0, 1'b1};
      vq.push_back('{"idle", 0, 0, 0, 0, 0, 32'h0, 0, 0, 4'h0});
      vq.push_back('{"basic_cfg", 1, 0, 1, 1, 0, 32'h0, 0, 0, 4'h0});
      vq.push_back('{"basic_r0", 1, 2, 1, 0, 1, 32'h1000, 1, 0, 4'h0});
      vq.push_back('{"basic_r1", 1, 2, 1, 0, 1, 32'h1040, 1, 0, 4'h0});
      vq.push_back('{"basic_r2", 1, 2, 1, 0, 1, 32'h1080, 1, 1, 4'h0});
      vq.push_back('{"top_cfg", 1, 1, 0, 1, 0, 32'h0, 0, 0, 4'h0});
      vq.push_back('{"top_r0", 0, 0, 1, 0, 1, 32'h2000, 0, 0, 4'h3});
      vq.push_back('{"top_r1", 0, 0, 1, 0, 1, 32'h2100, 0, 0, 4'h3});
      vq.push_back('{"top_r2", 0, 0, 1, 0, 1, 32'h2200, 1, 0, 4'h3});
      vq.push_back('{"top_r3", 0, 0, 1, 0, 1, 32'h2300, 1, 1, 4'h3});
      vq.push_back('{"top_idle", 0, 0, 0, 0, 0, 32'h0, 0, 0, 4'h0});
      vq.push_back('{"bot_cfg", 1, 3, 0, 1, 0, 32'h0, 0, 0, 4'h0});
      vq.push_back('{"bot_r0s", 0, 0, 0, 0, 1, 32'h3000, 1, 0, 4'h1});
      vq.push_back('{"bot_r0", 0, 0, 1, 0, 1, 32'h3000, 1, 0, 4'h1});
      vq.push_back('{"bot_r1s", 0, 0, 0, 0, 1, 32'h2FE0, 1, 0, 4'h1});
      vq.push_back('{"bot_r1", 0, 0, 1, 0, 1, 32'h2FE0, 1, 0, 4'h1});
      vq.push_back('{"bot_r2s", 0, 0, 0, 0, 1, 32'h2FC0, 0, 0, 4'h1});
      vq.push_back('{"bot_r2", 0, 0, 1, 0, 1, 32'h2FC0, 0, 0, 4'h1});
      vq.push_back('{"bot_r3s", 0, 0, 0, 0, 1, 32'h2FA0, 0, 1, 4'h1});
      vq.push_back('{"bot_r3", 0, 0, 1, 0, 1, 32'h2FA0, 0, 1, 4'h1});
      vq.push_back('{"empty_cfg", 1, 4, 0, 1, 0, 32'h0, 0, 0, 4'h0});
      vq.push_back('{"edge_cfg", 1, 5, 0, 1, 0, 32'h0, 0, 0, 4'h0});
      vq.push_back('{"edge_r0", 0, 0, 1, 0, 1, 32'h4000, 1, 1, 4'h2});
      vq.push_back('{"sgn_cfg", 1, 6, 0, 1, 0, 32'h0, 0, 0, 4'h0});
      vq.push_back('{"sgn_r0s", 0, 0, 0, 0, 1, 32'h8000, 0, 1, 4'h0});
      vq.push_back('{"sgn_r0", 0, 0, 1, 0, 1, 32'h8000, 0, 1, 4'h0});
      vq.push_back('{"stray_ack", 0, 0, 1, 0, 0, 32'h0, 0, 0, 4'h0});
`ifdef CHUNK_ROW_SCHED_WRAP_EN
      vq.push_back('{"wrap_cfg", 1, 7, 0, 1, 0, 32'h0, 0, 0, 4'h0});
      vq.push_back('{"wrap_r0", 0, 0, 1, 0, 1, 32'h120, 1, 0, 4'h0});
      vq.push_back('{"wrap_r1", 0, 0, 1, 0, 1, 32'h130, 1, 0, 4'h0});
      vq.push_back('{"wrap_r2", 0, 0, 1, 0, 1, 32'h100, 1, 0, 4'h0});
      vq.push_back('{"wrap_r3", 0, 0, 1, 0, 1, 32'h110, 1, 1, 4'h0});
      vq.push_back('{"wrap_idle", 0, 0, 0, 0, 0, 32'h0, 0, 0, 4'h0});
`endif
      cyc();
      chk("reset", 0, 0, 32'h0, 0, 0, 4'h0);
      cyc();
      i_rst = 1'b0;
      foreach (vq[k]) begin
         set_cfg(vq[k].cr, cfgs[vq[k].ci], vq[k].ack);
         chk(vq[k].n, vq[k].cack, vq[k].rdy, vq[k].lin, vq[k].val, vq[k].last, vq[k].pad);
         cyc();
      end
      // reset lands while the third of five rows is presented
      set_cfg(1, '{32'h5000, 32'h8, 32'h0, 16'h0, 16'd5, 16'd8, 4'h6, 1'b0}, 0);
      chk("rst_cfg", 1, 0, 32'h0, 0, 0, 4'h0);
      cyc();
      cfg_rdy = 1'b0;
      row_ack = 1'b1;
      chk("rst_r0", 0, 1, 32'h5000, 1, 0, 4'h6);
      cyc();
      chk("rst_r1", 0, 1, 32'h5008, 1, 0, 4'h6);
      cyc();
      i_rst = 1'b1;
      chk("rst_r2", 0, 1, 32'h5010, 1, 0, 4'h6);
      cyc();
      i_rst = 1'b0;
      chk("rst_after", 0, 0, 32'h0, 0, 0, 4'h0);
      cyc();
      chk("rst_quiet", 0, 0, 32'h0, 0, 0, 4'h0);
      cyc();
      set_cfg(1, '{32'h6000, 32'h8, 32'h0, 16'd1, 16'd1, 16'd8, 4'h5, 1'b0}, 0);
      chk("post_cfg", 1, 0, 32'h0, 0, 0, 4'h0);
      cyc();
      cfg_rdy = 1'b0;
      row_ack = 1'b1;
      chk("post_r0", 0, 1, 32'h6000, 1, 1, 4'h5);
      cyc();
      chk("post_idle", 0, 0, 32'h0, 0, 0, 4'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/chunk_row_sched.md
# chunk_row_sched

Row sequencer that drives the row handshake of the chunk-row command generator in the read pipeline's chunk address looper. One configuration describes a vertical tile window. The block then emits one row descriptor per cycle under `rdy`/`ack`:

- linear address
- valid flag
- pad length
- last flag

It flags rows outside the vertical bound as invalid, so the downstream block converts them into border/pad commands.

## Interface
Parameters:
- `GBW`, default `TauCfg::GLOBAL_ADDR_BW`: global address width.
- `VSIZE`, default `TauCfg::VSIZE`: vector size. Derived `V_BW = $clog2(VSIZE)`.
- `CNT_BW`, default 16: row-count and row-index width.

Ports:
- `i_clk`  in  1: clock.
- `i_rst`  in  1: synchronous, active-high reset.
- `cfg_rdy`  in  1: configuration valid.
- `cfg_ack`  out  1: configuration accepted.
- `i_base`  in  GBW: linear address of the first row. May lie outside the valid region.
- `i_stride`  in  GBW: linear distance between rows. Two's complement.
- `i_ystart`  in  CNT_BW: signed vertical index of the first row.
- `i_nrow`  in  CNT_BW: unsigned row count.
- `i_ybound`  in  CNT_BW: valid rows are `0 <= y < i_ybound`.
- `i_pad`  in  V_BW: pad length, copied to every row.
- `i_wrap`  in  1: vertical wrap enable. Present only with `CHUNK_ROW_SCHED_WRAP_EN`.
- `i_span`  in  GBW: equals `i_ybound*i_stride`. Present only with `CHUNK_ROW_SCHED_WRAP_EN`.
- `row_rdy`  out  1: row descriptor valid.
- `row_ack`  in  1: row consumed.
- `o_row_linear`  out  GBW
- `o_row_islast`  out  1
- `o_row_pad`  out  V_BW
- `o_row_valid`  out  1
- `o_busy`  out  1: high in EMIT.

## Operation
- The FSM has two states, IDLE and EMIT.
- **IDLE:**
  - `cfg_ack = cfg_rdy`, combinational.
  - On accept, latch all cfg fields and set `y = i_ystart`, `lin = i_base`, `remain = i_nrow`.
  - Go to EMIT if `i_nrow != 0`; otherwise stay in IDLE.
- **EMIT:**
  - `row_rdy = 1`, `cfg_ack = 0`.
  - Outputs are registered:
    - `o_row_linear = lin`
    - `o_row_valid = ($signed(y) >= 0) && (y < ybound)`, where `y` is signed and `ybound` unsigned, compared at `CNT_BW+1` bits.
    - `o_row_pad = pad`
    - `o_row_islast = (remain == 1)`
  - On `row_ack`:
    - `y += 1`, `lin += stride` (modulo `2^GBW`), `remain -= 1`.
    - If `remain` was 1, go to IDLE.
- **Wrap:** see Configuration.
- `row_ack` without `row_rdy` is ignored. `cfg_rdy` during EMIT is held off.
- The latched cfg fields are not affected by input changes after accept.

## Timing
- Reset values: FSM=IDLE, `row_rdy=0`, `o_row_linear=0`, `o_row_islast=0`, `o_row_pad=0`, `o_row_valid=0`, `o_busy=0`. `cfg_ack` follows `cfg_rdy` from the first post-reset cycle.
- cfg accepted in cycle N means the first `row_rdy` is in cycle N+1.
- Throughput is one row per cycle while `row_ack` is held high.
- The last row acked in cycle M means IDLE in M+1. The earliest next `cfg_ack` is M+1, and the next first row is M+2.
- Output fields are stable while `row_rdy && !row_ack`.
- `i_nrow=0`: `cfg_ack` is pulsed, no row is emitted, and the FSM stays IDLE.
- Reset asserted mid-EMIT: at the next edge the FSM returns to IDLE with all outputs at reset values. No partial row is presented afterward.

## Configuration
- `CHUNK_ROW_SCHED_WRAP_EN` defined:
  - Ports `i_wrap` and `i_span` exist and are latched at accept.
  - When `wrap=1`, the ack-time update wraps: if `y+1 == ybound`, then `y <= 0` and `lin <= lin + stride - span`.
  - Every row in range is reported valid. The legal config requires `0 <= ystart < ybound`.
  - When `wrap=0`, behaviour is identical to the undefined case.
- Undefined: the ports are absent, there is no wrap logic, and out-of-range rows are reported `o_row_valid=0`.

## Test plan
- **Basic:** base=0x1000, stride=0x40, ystart=0, nrow=3, ybound=8, pad=0, `row_ack` held high → linear 0x1000/0x1040/0x1080 with valid=1, islast only on the third row; IDLE the following cycle.
- **Top border:** ystart=-2, nrow=4, ybound=8 → valid 0,0,1,1; linears continue from base by stride.
- **Bottom border, backpressure:** ystart=6, nrow=4, ybound=8, `row_ack` alternating 0/1 → valid 1,1,0,0; outputs hold across the stall cycles; 8 cycles total from first `row_rdy`.
- **Empty config:** `i_nrow=0` → one `cfg_ack`, `row_rdy` never asserted; a second config is accepted the following cycle.
- **Reset mid-stream:** `i_rst` asserted after 2 of 5 rows → `row_rdy=0` and all outputs zero next cycle; a new cfg then starts from its own base.
- **Wrap (macro defined):** wrap=1, ybound=4, ystart=2, nrow=4, stride=0x10, base=0x120, span=0x40 → linear 0x120, 0x130, 0x100, 0x110; all valid.
